rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Write-port scheduler and scoreboard for the pipelined CPU's 32x32 register file (one write port, two read ports).
- Shares the single write port between the in-order pipeline WB stage and the multicycle long-latency unit (multiply/divide).
- Tracks destination registers pending on long ops and stalls ID on RAW/WAW hazards.
- Sits between ID/WB control and the register file write inputs.

Parameters:
MAX_PEND, 4, maximum outstanding long ops; range 1..7.
CNT_W, 3, width of pend_cnt; must hold MAX_PEND.
STARVE_MAX, 3, consecutive denied cycles before long unit forces a WB slot; range 1..15.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  instruction present in ID
id_ra  in  5  source register A (rs)
id_rb  in  5  source register B (rt)
id_rw  in  5  destination register (rt|rd)
id_wr  in  1  instruction writes id_rw
id_long  in  1  instruction is dispatched to long unit
id_stall  out  1  hold ID; instruction not accepted
pipe_wb_valid  in  1  WB stage requests a write
pipe_wb_rw  in  5  WB destination
pipe_wb_data  in  32  WB data
pipe_overflow  in  1  WB instruction overflowed; write suppressed
lu_valid  in  1  long unit result available
lu_rw  in  5  long unit destination
lu_data  in  32  long unit result
lu_ready  out  1  long unit result accepted this cycle
pipe_hold  out  1  freeze entire pipeline for one cycle
rf_wr  out  1  register file write enable
rf_rw  out  5  register file write address
rf_busw  out  32  register file write data
busy_vec  out  32  per-register pending-long-write flags; bit 0 always 0
pend_cnt  out  CNT_W  number of set busy bits

Behaviour:
- Reset (async, rst_n=0): busy_vec=0, pend_cnt=0, starvation counter=0, so pipe_hold=0. Write-port outputs follow their inputs combinationally.
- Hazard (combinational):
  - id_stall = id_valid & (busy[id_ra] | busy[id_rb] | (id_wr & busy[id_rw]) | (id_long & id_wr & pend_cnt==MAX_PEND)).
  - Index 0 is never busy.
- Issue accept: acc = id_valid & ~id_stall & ~pipe_hold. On acc & id_long & id_wr & id_rw!=0, set busy[id_rw] at the next edge.
- Arbitration (combinational, same cycle):
  - pipe_hold=1: long unit granted, pipe_wb ignored (pipeline frozen, WB re-presents next cycle).
  - Else pipe_wb_valid=1: pipe granted.
  - Else lu_valid: long unit granted.
  - lu_ready = lu_valid & granted-to-lu.
- Write port:
  - Pipe grant: rf_wr = ~pipe_overflow, rf_rw=pipe_wb_rw, rf_busw=pipe_wb_data.
  - LU grant: rf_wr=1, rf_rw=lu_rw, rf_busw=lu_data.
  - No grant: rf_wr=0, rf_rw=0, rf_busw=0.
  - Any grant with rw==0: rf_wr=0.
- Busy clear: lu_ready clears busy[lu_rw] at the next edge. The clear is not visible until the next cycle; no same-cycle bypass.
- Set and clear of the same register in one cycle: set wins, bit stays 1. Unreachable under the WAW stall; must still be defined.
- pend_cnt = popcount(busy_vec), kept registered and consistent: +1 on set, -1 on clear, unchanged on simultaneous set+clear.
- Starvation counter:
  - Increments when lu_valid & ~lu_ready, saturating at STARVE_MAX.
  - Resets to 0 on lu_ready or ~lu_valid.
  - pipe_hold = (counter==STARVE_MAX) & lu_valid, a registered-state decode.
- lu_valid with lu_rw not busy: write performed, no busy change, no error.
- Reset mid-operation: all pending flags dropped immediately. The long unit must be reset alongside.

Test Plan:
- Reset with id_valid=1, id_ra=5: busy_vec=0, pend_cnt=0, id_stall=0, pipe_hold=0, rf_wr=0.
- Issue long to $8 (id_long=1, id_wr=1, id_rw=8), next cycle id_ra=8 -> busy_vec[8]=1, pend_cnt=1, id_stall=1 until the cycle after lu_valid,lu_rw=8,lu_data=32'h1234 is accepted; rf_wr=1, rf_rw=8, rf_busw=32'h1234 during accept.
- Same cycle pipe_wb_valid (rw=3, data=32'hAA) and lu_valid (rw=8): rf_rw=3, lu_ready=0. After 3 such cycles pipe_hold=1, lu_ready=1, rf_rw=8, counter back to 0.
- pipe_wb_valid=1, pipe_overflow=1, rw=9 -> rf_wr=0, busy_vec unchanged. pipe_wb_rw=0 or lu_rw=0 -> rf_wr=0.
- Issue 4 long ops to $1..$4, then a 5th long to $5 -> pend_cnt=4, id_stall=1. Non-long issue reading $6 still accepted (id_stall=0).
- busy_vec=32'h0000_0110, assert rst_n=0 mid-cycle -> busy_vec=0 and pend_cnt=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of ID-stage, WB-stage, long-unit and register-file write-port signals around the scheduler.
// The master side drives the requests; the slave side is the scheduler.
interface rf_wb_scheduler_if #(
    parameter int CNT_W = 3
);
    logic             id_valid;
    logic [4:0]       id_ra;
    logic [4:0]       id_rb;
    logic [4:0]       id_rw;
    logic             id_wr;
    logic             id_long;
    logic             id_stall;
    logic             pipe_wb_valid;
    logic [4:0]       pipe_wb_rw;
    logic [31:0]      pipe_wb_data;
    logic             pipe_overflow;
    logic             lu_valid;
    logic [4:0]       lu_rw;
    logic [31:0]      lu_data;
    logic             lu_ready;
    logic             pipe_hold;
    logic             rf_wr;
    logic [4:0]       rf_rw;
    logic [31:0]      rf_busw;
    logic [31:0]      busy_vec;
    logic [CNT_W-1:0] pend_cnt;

    modport master (
        output id_valid, id_ra, id_rb, id_rw, id_wr, id_long,
        output pipe_wb_valid, pipe_wb_rw, pipe_wb_data, pipe_overflow,
        output lu_valid, lu_rw, lu_data,
        input  id_stall, lu_ready, pipe_hold, rf_wr, rf_rw, rf_busw, busy_vec, pend_cnt
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_rw, id_wr, id_long,
        input  pipe_wb_valid, pipe_wb_rw, pipe_wb_data, pipe_overflow,
        input  lu_valid, lu_rw, lu_data,
        output id_stall, lu_ready, pipe_hold, rf_wr, rf_rw, rf_busw, busy_vec, pend_cnt
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter (WB vs long unit) plus long-op scoreboard; write port is combinational, busy/count/starvation update at the edge.
// Backpressure: id_stall holds ID on RAW/WAW/full, lu_ready withholds the long unit, pipe_hold freezes the pipe after STARVE_MAX denials.
module rf_wb_scheduler #(
    parameter int MAX_PEND   = 4,
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst_n,
    rf_wb_scheduler_if.slave bus
);
    localparam int SW = 4;

    logic [31:0]      busy_q, busy_d, set_vec, clr_vec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             acc, grant_pipe, grant_lu;
    logic             set_en, clr_en, inc, dec;

    assign bus.pipe_hold = (starve_q == SW'(STARVE_MAX)) & bus.lu_valid;

    assign bus.id_stall = bus.id_valid &
                          (busy_q[bus.id_ra] | busy_q[bus.id_rb] |
                           (bus.id_wr & busy_q[bus.id_rw]) |
                           (bus.id_long & bus.id_wr & (cnt_q == CNT_W'(MAX_PEND))));

    assign acc        = bus.id_valid & ~bus.id_stall & ~bus.pipe_hold;
    assign grant_pipe = bus.pipe_wb_valid & ~bus.pipe_hold;
    assign grant_lu   = bus.lu_valid & ~grant_pipe;
    assign bus.lu_ready = grant_lu;

    always_comb begin
        bus.rf_wr   = 1'b0;
        bus.rf_rw   = 5'd0;
        bus.rf_busw = 32'd0;
        if (grant_pipe) begin
            bus.rf_wr   = ~bus.pipe_overflow & (bus.pipe_wb_rw != 5'd0);
            bus.rf_rw   = bus.pipe_wb_rw;
            bus.rf_busw = bus.pipe_wb_data;
        end else if (grant_lu) begin
            bus.rf_wr   = (bus.lu_rw != 5'd0);
            bus.rf_rw   = bus.lu_rw;
            bus.rf_busw = bus.lu_data;
        end
    end

    assign set_en = acc & bus.id_long & bus.id_wr & (bus.id_rw != 5'd0);
    assign clr_en = grant_lu & (bus.lu_rw != 5'd0);

    // Count tracks actual bit transitions so it always equals the popcount,
    // including the set-wins case and clears of registers that were never busy.
    assign inc = set_en & ~busy_q[bus.id_rw];
    assign dec = clr_en & busy_q[bus.lu_rw] & ~(set_en & (bus.id_rw == bus.lu_rw));

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[bus.id_rw] = 1'b1;
        if (clr_en) clr_vec[bus.lu_rw] = 1'b1;
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
        cnt_d     = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.lu_valid || grant_lu)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign bus.busy_vec = busy_q;
    assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomized scoreboard bench for rf_wb_scheduler against a per-register pending-set model.
// Stimulus pushes predicted outputs per cycle; a negedge monitor pops and compares.
module tb_rf_wb_scheduler;
    localparam int MAX_PEND   = 4;
    localparam int CNT_W      = 3;
    localparam int STARVE_MAX = 3;

    typedef struct {
        logic        idv;
        logic [4:0]  ra, rb, rw;
        logic        wr, lng;
        logic        pwv;
        logic [4:0]  prw;
        logic [31:0] pdat;
        logic        povf;
        logic        luv;
        logic [4:0]  lrw;
        logic [31:0] ldat;
    } stim_t;

    typedef struct {
        logic        stall, lrdy, hold, rfwr;
        logic [4:0]  rfrw;
        logic [31:0] busw, busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_scheduler_if #(.CNT_W(CNT_W)) bus ();

    rf_wb_scheduler #(
        .MAX_PEND  (MAX_PEND),
        .CNT_W     (CNT_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: which registers await a long-unit result, in issue order.
    bit   pend[32];
    int   starve;
    logic [4:0] luq[$];
    exp_t expq[$];

    bit          lu_active;
    logic [4:0]  lu_rw_cur;
    logic [31:0] lu_dat_cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.idv = 0; s.ra = 0; s.rb = 0; s.rw = 0; s.wr = 0; s.lng = 0;
        s.pwv = 0; s.prw = 0; s.pdat = 0; s.povf = 0;
        s.luv = 0; s.lrw = 0; s.ldat = 0;
        return s;
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        int n;
        n = 0;
        e.busy = '0;
        for (int i = 1; i < 32; i++) if (pend[i]) begin n++; e.busy[i] = 1'b1; end
        e.cnt   = CNT_W'(n);
        e.stall = s.idv && (pend[s.ra] || pend[s.rb] || (s.wr && pend[s.rw]) ||
                            (s.lng && s.wr && n == MAX_PEND));
        e.hold  = (starve == STARVE_MAX) && s.luv;
        e.rfwr = 0; e.rfrw = 0; e.busw = 0; e.lrdy = 0;
        if (!e.hold && s.pwv) begin
            e.rfwr = !s.povf && s.prw != 0; e.rfrw = s.prw; e.busw = s.pdat;
        end else if (s.luv) begin
            e.lrdy = 1; e.rfwr = s.lrw != 0; e.rfrw = s.lrw; e.busw = s.ldat;
        end
        return e;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid = s.idv; bus.id_ra = s.ra; bus.id_rb = s.rb; bus.id_rw = s.rw;
        bus.id_wr = s.wr; bus.id_long = s.lng;
        bus.pipe_wb_valid = s.pwv; bus.pipe_wb_rw = s.prw; bus.pipe_wb_data = s.pdat;
        bus.pipe_overflow = s.povf;
        bus.lu_valid = s.luv; bus.lu_rw = s.lrw; bus.lu_data = s.ldat;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        starve = 0;
        luq.delete();
        lu_active = 0;
    endtask

    task automatic run_cycle(input stim_t s, output exp_t e);
        bit set, clr;
        apply(s);
        e = predict(s);
        expq.push_back(e);
        @(posedge clk);
        #1;
        set = s.idv && !e.stall && !e.hold && s.lng && s.wr && s.rw != 0;
        clr = e.lrdy && s.lrw != 0;
        if (clr) pend[s.lrw] = 0;
        if (set) pend[s.rw] = 1;
        if (!s.luv || e.lrdy) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        if (e.lrdy && luq.size() > 0 && luq[0] == s.lrw) void'(luq.pop_front());
        if (set) luq.push_back(s.rw);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("id_stall",  32'(bus.id_stall),  32'(e.stall));
            chk("lu_ready",  32'(bus.lu_ready),  32'(e.lrdy));
            chk("pipe_hold", 32'(bus.pipe_hold), 32'(e.hold));
            chk("rf_wr",     32'(bus.rf_wr),     32'(e.rfwr));
            chk("rf_rw",     32'(bus.rf_rw),     32'(e.rfrw));
            chk("rf_busw",   bus.rf_busw,        e.busw);
            chk("busy_vec",  bus.busy_vec,       e.busy);
            chk("pend_cnt",  32'(bus.pend_cnt),  32'(e.cnt));
        end
    end

    function automatic stim_t long_op(input logic [4:0] rw);
        stim_t s;
        s = idle();
        s.idv = 1; s.lng = 1; s.wr = 1; s.rw = rw;
        return s;
    endfunction

    task automatic drain_lu();
        stim_t s;
        exp_t  e;
        for (int k = 0; k < 64 && luq.size() > 0; k++) begin
            s = idle();
            s.luv = 1; s.lrw = luq[0]; s.ldat = $urandom;
            run_cycle(s, e);
        end
        chk("drain_empty", 32'(luq.size()), 32'd0);
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        model_reset();

        // Reset state with an instruction sitting in ID.
        s = idle();
        s.idv = 1; s.ra = 5;
        apply(s);
        #3;
        chk("rst_busy_vec",  bus.busy_vec,        32'd0);
        chk("rst_pend_cnt",  32'(bus.pend_cnt),   32'd0);
        chk("rst_id_stall",  32'(bus.id_stall),   32'd0);
        chk("rst_pipe_hold", 32'(bus.pipe_hold),  32'd0);
        chk("rst_rf_wr",     32'(bus.rf_wr),      32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Long op to $8, then dependent reads until the result returns.
        run_cycle(long_op(5'd8), e);
        s = idle(); s.idv = 1; s.ra = 8;
        run_cycle(s, e);
        run_cycle(s, e);
        s.luv = 1; s.lrw = 8; s.ldat = 32'h1234;
        run_cycle(s, e);
        s.luv = 0;
        run_cycle(s, e);

        // WB collides with long unit until starvation forces a hold.
        run_cycle(long_op(5'd8), e);
        for (int k = 0; k < STARVE_MAX + 1; k++) begin
            s = idle();
            s.pwv = 1; s.prw = 3; s.pdat = 32'hAA;
            s.luv = 1; s.lrw = 8; s.ldat = 32'h5678;
            run_cycle(s, e);
        end
        chk("starve_granted", 32'(e.lrdy), 32'd1);

        // Overflow suppression and writes to $0.
        s = idle(); s.pwv = 1; s.povf = 1; s.prw = 9; s.pdat = 32'hDEAD;
        run_cycle(s, e);
        s.povf = 0; s.prw = 0;
        run_cycle(s, e);
        s = idle(); s.luv = 1; s.lrw = 0; s.ldat = 32'hBEEF;
        run_cycle(s, e);

        // Fill the scoreboard, hit the limit, and show a non-long op still issues.
        for (int r = 1; r <= 4; r++) run_cycle(long_op(5'(r)), e);
        run_cycle(long_op(5'd5), e);
        chk("full_stall", 32'(e.stall), 32'd1);
        s = idle(); s.idv = 1; s.ra = 6; s.wr = 1; s.rw = 7;
        run_cycle(s, e);
        chk("nonlong_accept", 32'(e.stall), 32'd0);
        drain_lu();

        // Asynchronous reset with $4 and $8 pending.
        run_cycle(long_op(5'd4), e);
        run_cycle(long_op(5'd8), e);
        apply(idle());
        #2;
        chk("pre_rst_busy", bus.busy_vec, 32'h0000_0110);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy_vec,      32'd0);
        chk("async_rst_cnt",  32'(bus.pend_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            s = idle();
            s.idv = ($urandom % 4) != 0;
            s.ra  = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
            s.rb  = 5'($urandom_range(0, 11));
            s.rw  = 5'($urandom_range(0, 11));
            s.wr  = ($urandom % 4) != 0;
            s.lng = ($urandom % 3) == 0;
            s.pwv = ($urandom % 2) == 0;
            s.prw = 5'($urandom);
            s.pdat = $urandom;
            s.povf = ($urandom % 8) == 0;
            if (!lu_active) begin
                if (luq.size() > 0 && $urandom % 3 == 0) begin
                    lu_active = 1; lu_rw_cur = luq[0]; lu_dat_cur = $urandom;
                end else if (luq.size() == 0 && $urandom % 16 == 0) begin
                    lu_active = 1; lu_rw_cur = 5'($urandom); lu_dat_cur = $urandom;
                end
            end
            s.luv = lu_active; s.lrw = lu_rw_cur; s.ldat = lu_dat_cur;
            run_cycle(s, e);
            if (e.lrdy) lu_active = 0;
        end
        apply(idle());
        drain_lu();

        for (int k = 0; k < 4 && expq.size() > 0; k++) @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
